// File: rtl/caxi4interconnect_reg_slice_rev_if.sv
// Channel bundle for the ready-path register slice.
// master: source/sink side (bench or surrounding fabric); slave: the slice itself.
interface caxi4interconnect_reg_slice_rev_if #(
  parameter int CHAN_WIDTH = 5
);
  logic [CHAN_WIDTH-1:0] mDat;
  logic                  mValid;
  logic                  mReady;
  logic [CHAN_WIDTH-1:0] sDat;
  logic                  sValid;
  logic                  sReady;

  modport master (
    output mDat, mValid, sReady,
    input  mReady, sDat, sValid
  );

  modport slave (
    input  mDat, mValid, sReady,
    output mReady, sDat, sValid
  );
endinterface

// File: rtl/caxi4interconnect_reg_slice_rev.sv
// Reverse (ready-path) register slice: data/valid pass through with zero
// latency, mReady is registered, and a one-entry skid register holds the
// beat that was in flight when the sink stalled. Includes a saturating
// stall-cycle counter for debug.
module caxi4interconnect_reg_slice_rev #(
  parameter int CHAN_WIDTH      = 5,
  parameter int STALL_CNT_WIDTH = 8
) (
  input  logic                       sysClk,
  input  logic                       sysReset,
  caxi4interconnect_reg_slice_rev_if.slave chan,
  input  logic                       stallCntClr,
  output logic                       skidFull,
  output logic [STALL_CNT_WIDTH-1:0] stallCnt
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] PASS = 2'b01;
  localparam logic [1:0] SKID = 2'b10;

  logic [1:0]            state;
  logic [1:0]            nextState;
  logic [CHAN_WIDTH-1:0] skidDat;
  logic                  mReadyQ;
  logic                  skidLoad;

  // Next-state decode; the unused encoding falls back to IDLE.
  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE:    nextState = PASS;
      PASS:    nextState = (chan.mValid && !chan.sReady) ? SKID : PASS;
      SKID:    nextState = chan.sReady ? PASS : SKID;
      default: nextState = IDLE;
    endcase
  end

  // In PASS mReady is always 1, so mValid alone means a beat was accepted.
  assign skidLoad = (state == PASS) && chan.mValid && !chan.sReady;

  // State register and registered ready (high only when heading into PASS).
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state   <= IDLE;
      mReadyQ <= 1'b0;
    end else begin
      state   <= nextState;
      mReadyQ <= (nextState == PASS);
    end
  end

  // Skid register captures the beat accepted while the sink stalls.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      skidDat <= '0;
    end else if (skidLoad) begin
      skidDat <= chan.mDat;
    end
  end

  // Saturating count of cycles spent in SKID; clear wins over increment.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      stallCnt <= '0;
    end else if (stallCntClr) begin
      stallCnt <= '0;
    end else if ((state == SKID) && (stallCnt != '1)) begin
      stallCnt <= stallCnt + STALL_CNT_WIDTH'(1);
    end
  end

  assign chan.mReady = mReadyQ;
  assign chan.sValid = ((state == PASS) && chan.mValid) || (state == SKID);
  assign chan.sDat   = (state == SKID) ? skidDat : chan.mDat;
  assign skidFull    = (state == SKID);

endmodule

// File: tb/tb_caxi4interconnect_reg_slice_rev.sv
// Scoreboard bench for the ready-path register slice.
module tb_caxi4interconnect_reg_slice_rev;

  localparam int CW = 5;
  localparam int SW = 4;

  logic          sysClk;
  logic          sysReset;
  logic          stallCntClr;
  logic          skidFull;
  logic [SW-1:0] stallCnt;

  caxi4interconnect_reg_slice_rev_if #(.CHAN_WIDTH(CW)) chan ();

  caxi4interconnect_reg_slice_rev #(
    .CHAN_WIDTH     (CW),
    .STALL_CNT_WIDTH(SW)
  ) dut (
    .sysClk     (sysClk),
    .sysReset   (sysReset),
    .chan       (chan),
    .stallCntClr(stallCntClr),
    .skidFull   (skidFull),
    .stallCnt   (stallCnt)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] expQ[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: push accepted beats, pop and compare delivered beats, check invariants.
  initial begin
    logic [CW-1:0] exp;
    forever begin
      @(negedge sysClk);
      if (sysReset) begin
        expQ.delete();
      end else begin
        if (dut.state == 2'b00) chk("sValidInIdle", chan.sValid, 1'b0);
        if (dut.state == 2'b01 || dut.state == 2'b10)
          chk("mReadyVsSkid", chan.mReady, !skidFull);
        if (chan.mValid && chan.mReady) expQ.push_back(chan.mDat);
        if (chan.sValid && chan.sReady) begin
          if (expQ.size() == 0) begin
            chk("unexpectedBeat", chan.sDat, 32'hDEAD);
          end else begin
            exp = expQ.pop_front();
            chk("beatData", chan.sDat, exp);
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [CW-1:0] d, input logic r);
    @(posedge sysClk); #1;
    chan.mValid = v;
    chan.mDat   = d;
    chan.sReady = r;
  endtask

  initial begin
    logic hs;
    sysReset    = 1'b1;
    stallCntClr = 1'b0;
    chan.mValid = 1'b1;
    chan.mDat   = 5'h01;
    chan.sReady = 1'b1;
    repeat (3) @(posedge sysClk);
    #1;
    chk("rstSValid", chan.sValid, 1'b0);
    chk("rstMReady", chan.mReady, 1'b0);
    chk("rstSDatPass", chan.sDat, 5'h01);
    chk("rstStallCnt", stallCnt, 0);
    @(negedge sysClk); sysReset = 1'b0;

    // Reset release: cycle 0 then three back-to-back beats.
    #1;
    chk("c0MReady", chan.mReady, 1'b0);
    chk("c0SValid", chan.sValid, 1'b0);
    @(negedge sysClk);
    chk("c1MReady", chan.mReady, 1'b1);
    chk("c1SDat", chan.sDat, 5'h01);
    drive(1'b1, 5'h02, 1'b1);
    @(negedge sysClk); chk("c2SDat", chan.sDat, 5'h02);
    drive(1'b1, 5'h03, 1'b1);
    @(negedge sysClk); chk("c3SDat", chan.sDat, 5'h03);
    chk("c3SValid", chan.sValid, 1'b1);

    // Stall then release.
    drive(1'b1, 5'h0A, 1'b0);
    drive(1'b1, 5'h0B, 1'b0);
    @(negedge sysClk);
    chk("stallSkidFull", skidFull, 1'b1);
    chk("stallMReady", chan.mReady, 1'b0);
    chk("stallSDat", chan.sDat, 5'h0A);
    chk("stallSValid", chan.sValid, 1'b1);
    drive(1'b1, 5'h0B, 1'b1);
    @(negedge sysClk); chk("relSDat", chan.sDat, 5'h0A);
    @(negedge sysClk);
    chk("relMReady", chan.mReady, 1'b1);
    chk("relSDat2", chan.sDat, 5'h0B);
    drive(1'b0, 5'h00, 1'b1);
    @(negedge sysClk); chk("drainedQ", expQ.size(), 0);

    // Random traffic with AXI-stable source.
    for (int i = 0; i < 10000; i++) begin
      @(negedge sysClk);
      hs = chan.mValid & chan.mReady;
      @(posedge sysClk); #1;
      if (!chan.mValid || hs) begin
        chan.mValid = 1'($urandom_range(0, 1));
        chan.mDat   = CW'($urandom);
      end
      chan.sReady = 1'($urandom_range(0, 1));
    end
    drive(1'b0, 5'h00, 1'b1);
    repeat (3) @(negedge sysClk);
    chk("randDrainedQ", expQ.size(), 0);

    // Stall counter saturation and clear, skid holding 0x1F.
    drive(1'b1, 5'h1F, 1'b0);
    repeat (21) @(negedge sysClk);
    chk("cntSat", stallCnt, 15);
    @(posedge sysClk); #1; stallCntClr = 1'b1;
    @(negedge sysClk); chk("cntBeforeClr", stallCnt, 15);
    @(posedge sysClk); #1; stallCntClr = 1'b0;
    @(negedge sysClk);
    chk("cntCleared", stallCnt, 0);
    chk("cntClrSkid", skidFull, 1'b1);
    @(negedge sysClk); chk("cntResume1", stallCnt, 1);
    @(negedge sysClk); chk("cntResume2", stallCnt, 2);
    chk("skidDat1F", chan.sDat, 5'h1F);

    // Asynchronous reset mid-stall.
    #2 sysReset = 1'b1;
    #1;
    chk("arstSValid", chan.sValid, 1'b0);
    chk("arstMReady", chan.mReady, 1'b0);
    chk("arstSkidFull", skidFull, 1'b0);
    chk("arstStallCnt", stallCnt, 0);
    chan.mValid = 1'b0;
    chan.sReady = 1'b1;
    repeat (2) @(posedge sysClk);
    @(negedge sysClk); sysReset = 1'b0;
    #1; chk("arstC0MReady", chan.mReady, 1'b0);
    @(negedge sysClk); chk("arstC1MReady", chan.mReady, 1'b1);

    // Illegal state recovers through IDLE.
    @(negedge sysClk); #1;
    force dut.state = 2'b11;
    #1 chk("illegalSValid", chan.sValid, 1'b0);
    #1 release dut.state;
    drive(1'b1, 5'h15, 1'b1);
    @(negedge sysClk);
    chk("recovIdle", dut.state, 2'b00);
    chk("recovSValid", chan.sValid, 1'b0);
    chk("recovMReady", chan.mReady, 1'b0);
    @(negedge sysClk);
    chk("recovPass", dut.state, 2'b01);
    chk("recovSDat", chan.sDat, 5'h15);
    drive(1'b0, 5'h00, 1'b1);
    repeat (2) @(negedge sysClk);
    chk("finalQ", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/caxi4interconnect_reg_slice_rev.md
Name: caxi4interconnect_reg_slice_rev

Overview:
- Ready-path (reverse) register slice: the counterpart of the forward data/valid slice.
- Registers the backward ready signal toward the master/source so the upstream ready path is timing-isolated.
- Data/valid pass through combinationally with zero latency; a 1-entry skid register absorbs the beat in flight when the sink stalls.
- Instantiated on AXI4 channels, alone or paired with the forward slice, where ready is the critical path. Includes a saturating stall counter for debug.

Parameters:
- CHAN_WIDTH, 5, number of channel data bits carried alongside valid/ready.
- STALL_CNT_WIDTH, 8, width of the saturating stall-cycle counter.

Ports:
- sysClk  input  1  single clock; all state on rising edge.
- sysReset  input  1  asynchronous, active-high reset; assert async, deassert synchronous to sysClk externally.
- mDat  input  CHAN_WIDTH  channel data from master/source.
- mValid  input  1  mDat valid.
- mReady  output  1  registered ready to master/source.
- sDat  output  CHAN_WIDTH  channel data to slave/sink.
- sValid  output  1  sDat valid.
- sReady  input  1  slave/sink accepting sDat.
- stallCntClr  input  1  synchronous clear of stallCnt.
- skidFull  output  1  skid register occupied (equals state==SKID).
- stallCnt  output  STALL_CNT_WIDTH  saturating count of cycles spent in SKID.

Behaviour:
- Internal state: skidDat[CHAN_WIDTH-1:0], state[1:0] with IDLE=00, PASS=01, SKID=10; 11 is illegal and recovers to IDLE on the next clock.
- Reset values: state=IDLE, mReady=0, skidDat=0, stallCnt=0. Consequently sValid=0, skidFull=0, and sDat=mDat (combinational).
- mReady is a flop driven by the next state: it is 1 iff nextState==PASS.
- sValid = (state==PASS & mValid) | (state==SKID). sValid must never assert in IDLE: mReady is 0 there, and asserting would duplicate a beat.
- sDat = (state==SKID) ? skidDat : mDat.
- Handshake rules:
  - Upstream transfer = mValid & mReady. Downstream transfer = sValid & sReady.
  - Once asserted, sValid/sDat stay stable until sReady; this holds automatically because the source obeys AXI stability and skidDat is frozen.
- Transitions:
  - IDLE -> PASS unconditionally after the first clock out of reset, so mReady rises at cycle 1 and is never high while in reset.
  - PASS, mValid & !sReady: capture skidDat<=mDat, go to SKID; mReady<=0.
  - PASS, any other case: stay in PASS; a beat with mValid & sReady passes through in the same cycle.
  - SKID, sReady: skid beat is consumed; go to PASS; mReady<=1. No new beat is accepted this cycle because mReady was 0.
  - SKID, !sReady: stay in SKID; mValid is ignored.
- Throughput and latency:
  - Zero-cycle data latency.
  - Sustained 1 beat/cycle while sReady stays high.
  - After a stall, one bubble upstream (mReady low for ≥1 cycle) but no lost or duplicated beats.
- stallCnt:
  - Increments by 1 each cycle state==SKID and saturates at all-ones.
  - stallCntClr has priority over increment and forces 0 on the next edge.
  - Reset clears it.
- Reset mid-operation: any skid content is discarded immediately and asynchronously; mReady and sValid drop in the same cycle. The bench treats the in-flight beat as lost.
- mValid & sReady in the same cycle as a PASS->SKID decision is not possible: SKID is entered only when sReady=0.

Test Plan:
- Reset release, mValid=1 held, sReady=1:
  - mReady=0 and sValid=0 at cycle 0; mReady=1 at cycle 1.
  - Beats 0x01,0x02,0x03 appear on sDat in cycles 1,2,3 with no bubbles.
- Stall then release:
  - In PASS, mDat=0x0A with mValid=1 and sReady=0 → next cycle skidFull=1, mReady=0, sDat=0x0A, sValid=1.
  - Change mDat to 0x0B: sDat stays 0x0A.
  - Raise sReady → 0x0A is consumed, then mReady=1, then 0x0B passes. Sink sees 0x0A,0x0B exactly once each.
- Random mValid/sReady over 10k cycles vs a scoreboard → output sequence equals input sequence, with no drops or duplicates. sValid never high in IDLE, and mReady==!skidFull outside IDLE.
- stallCnt with STALL_CNT_WIDTH=4:
  - Hold SKID for 20 cycles → stallCnt=15 (saturated).
  - Pulse stallCntClr → stallCnt=0 next cycle while still in SKID, then 1,2,... counting resumes.
- Async reset asserted mid-stall with skidFull=1, skidDat=0x1F → sValid=0, mReady=0, skidFull=0, stallCnt=0 without waiting for a clock edge. After release the IDLE→PASS sequence repeats.
- Force state=11 via the bench → next clock state=IDLE, then PASS; sValid=0 throughout recovery.
